// File: rtl/operand_fetch.sv
// Decode-side operand fetch: register-file read, EX/MEM/WB bypass, load-use
// interlock with stall counting, and the ID/EX pipeline register.
module operand_fetch #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic [AW-1:0]   in_rd,
  input  logic            in_rd_wr,
  input  logic            in_is_load,
  output logic [AW-1:0]   rf_ra1,
  output logic [AW-1:0]   rf_ra2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            ex_fwd_en,
  input  logic [AW-1:0]   ex_fwd_rd,
  input  logic [XLEN-1:0] ex_fwd_data,
  input  logic            mem_fwd_en,
  input  logic [AW-1:0]   mem_fwd_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_wa,
  input  logic [XLEN-1:0] wb_wd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [AW-1:0]   out_rd,
  output logic            out_rd_wr,
  output logic            out_is_load,
  output logic [31:0]     stall_cnt
);

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    sat_inc = (&cnt) ? cnt : cnt + 32'd1;
  endfunction

  // Youngest producer wins; a bypass naming x0 never matches a live source.
  function automatic logic [XLEN-1:0] sel_operand(
    input logic [AW-1:0]   rs,
    input logic [XLEN-1:0] rf_val,
    input logic            ex_en,
    input logic [AW-1:0]   ex_rd,
    input logic [XLEN-1:0] ex_data,
    input logic            mem_en,
    input logic [AW-1:0]   mem_rd,
    input logic [XLEN-1:0] mem_data,
    input logic            wb_en,
    input logic [AW-1:0]   wb_rd,
    input logic [XLEN-1:0] wb_data
  );
    if (rs == '0)                                  sel_operand = '0;
    else if (ex_en  && ex_rd  == rs)               sel_operand = ex_data;
    else if (mem_en && mem_rd == rs)               sel_operand = mem_data;
    else if (wb_en  && wb_rd  == rs)               sel_operand = wb_data;
    else                                           sel_operand = rf_val;
  endfunction

  function automatic logic reads_reg(
    input logic [AW-1:0] rs1,
    input logic [AW-1:0] rs2,
    input logic [AW-1:0] rd
  );
    reads_reg = ((rs1 != '0) && (rs1 == rd)) || ((rs2 != '0) && (rs2 == rd));
  endfunction

  logic            vld_p1;
  logic [XLEN-1:0] rs1_val_p1;
  logic [XLEN-1:0] rs2_val_p1;
  logic [AW-1:0]   rd_p1;
  logic            rd_wr_p1;
  logic            is_load_p1;

  logic            ld_trk_valid;
  logic [AW-1:0]   ld_trk_rd;
  logic [31:0]     stall_q;

  logic [XLEN-1:0] rs1_val_p0;
  logic [XLEN-1:0] rs2_val_p0;
  logic            hz;
  logic            accept;
  logic            consume;
  logic            ld_leaving;

  assign rf_ra1 = in_rs1;
  assign rf_ra2 = in_rs2;

  // ---- stage p0: operand resolve and interlock ----
  always_comb begin
    rs1_val_p0 = sel_operand(in_rs1, rf_rd1, ex_fwd_en, ex_fwd_rd, ex_fwd_data,
                             mem_fwd_en, mem_fwd_rd, mem_fwd_data, wb_we, wb_wa, wb_wd);
    rs2_val_p0 = sel_operand(in_rs2, rf_rd2, ex_fwd_en, ex_fwd_rd, ex_fwd_data,
                             mem_fwd_en, mem_fwd_rd, mem_fwd_data, wb_we, wb_wa, wb_wd);
  end

  // A load sitting in ID/EX, or one that just moved into EX, cannot feed a
  // dependent until its data appears on the MEM bypass.
  assign hz = in_valid &&
              ((vld_p1 && is_load_p1 && rd_wr_p1 && reads_reg(in_rs1, in_rs2, rd_p1)) ||
               (ld_trk_valid && reads_reg(in_rs1, in_rs2, ld_trk_rd)));

  assign in_ready   = rst_n && (!vld_p1 || out_ready) && !hz && !flush;
  assign accept     = in_valid && in_ready;
  assign consume    = vld_p1 && out_ready;
  assign ld_leaving = consume && is_load_p1 && rd_wr_p1 && (rd_p1 != '0);

  // ---- stage p1: ID/EX register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1       <= 1'b0;
      rs1_val_p1   <= '0;
      rs2_val_p1   <= '0;
      rd_p1        <= '0;
      rd_wr_p1     <= 1'b0;
      is_load_p1   <= 1'b0;
      ld_trk_valid <= 1'b0;
      ld_trk_rd    <= '0;
      stall_q      <= '0;
    end else begin
      if (flush) begin
        vld_p1 <= 1'b0;
      end else if (accept) begin
        vld_p1     <= 1'b1;
        rs1_val_p1 <= rs1_val_p0;
        rs2_val_p1 <= rs2_val_p0;
        rd_p1      <= in_rd;
        rd_wr_p1   <= in_rd_wr;
        is_load_p1 <= in_is_load;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end

      ld_trk_valid <= ld_leaving && !flush;
      if (ld_leaving) ld_trk_rd <= rd_p1;

      if (hz) stall_q <= sat_inc(stall_q);
    end
  end

  assign out_valid   = vld_p1;
  assign out_rs1_val = rs1_val_p1;
  assign out_rs2_val = rs2_val_p1;
  assign out_rd      = rd_p1;
  assign out_rd_wr   = rd_wr_p1;
  assign out_is_load = is_load_p1;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus a randomized run against
// a transaction-level model of bypass priority and load-use interlock.
module tb_operand_fetch;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, flush, in_valid, in_ready;
  logic [AW-1:0]   in_rs1, in_rs2, in_rd;
  logic            in_rd_wr, in_is_load;
  logic [AW-1:0]   rf_ra1, rf_ra2;
  logic [XLEN-1:0] rf_rd1, rf_rd2;
  logic            ex_fwd_en, mem_fwd_en, wb_we;
  logic [AW-1:0]   ex_fwd_rd, mem_fwd_rd, wb_wa;
  logic [XLEN-1:0] ex_fwd_data, mem_fwd_data, wb_wd;
  logic            out_valid, out_ready, out_rd_wr, out_is_load;
  logic [XLEN-1:0] out_rs1_val, out_rs2_val;
  logic [AW-1:0]   out_rd;
  logic [31:0]     stall_cnt;

  logic [XLEN-1:0] rf [32];
  int checks   = 0;
  int failures = 0;

  assign rf_rd1 = rf[rf_ra1];
  assign rf_rd2 = rf[rf_ra2];

  operand_fetch #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rd_wr(in_rd_wr), .in_is_load(in_is_load),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .ex_fwd_en(ex_fwd_en), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_rd(out_rd), .out_rd_wr(out_rd_wr), .out_is_load(out_is_load),
    .stall_cnt(stall_cnt)
  );

  // Advance one clock; the register file commits the WB write at the edge.
  task automatic tick();
    @(posedge clk);
    if (wb_we && wb_wa != '0) rf[wb_wa] = wb_wd;
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_rd_wr = 0; in_is_load = 0; out_ready = 1;
    ex_fwd_en = 0; ex_fwd_rd = 0; ex_fwd_data = 0;
    mem_fwd_en = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_we = 0; wb_wa = 0; wb_wd = 0;
  endtask

  task automatic issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input logic rd_wr, input logic ld);
    in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_rd_wr = rd_wr; in_is_load = ld;
  endtask

  task automatic drain();
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    issue(5'd1, 5'd2, 5'd3, 1, 0);
    tick(); tick();
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++;
    if (out_valid !== 1'b0 || stall_cnt !== 32'd0) begin
      failures++; $display("FAIL reset_state valid=%b stall=%0d exp valid=0 stall=0", out_valid, stall_cnt);
    end
    checks++;
    if (out_rs1_val !== '0 || out_rs2_val !== '0 || out_rd !== '0 || out_rd_wr !== 0 || out_is_load !== 0) begin
      failures++; $display("FAIL reset_fields rs1=%h rs2=%h rd=%0d exp all 0", out_rs1_val, out_rs2_val, out_rd);
    end
    rst_n = 1;
    idle_inputs();
    tick();
  endtask

  task automatic test_plain_read();
    rf[5] = 32'h1234; rf[6] = 32'hABCD;
    issue(5'd5, 5'd6, 5'd1, 1, 0);
    #1;
    checks++;
    if (rf_ra1 !== 5'd5 || rf_ra2 !== 5'd6 || in_ready !== 1'b1) begin
      failures++; $display("FAIL plain_addr ra1=%0d ra2=%0d rdy=%b exp 5 6 1", rf_ra1, rf_ra2, in_ready);
    end
    tick();
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || out_rs1_val !== 32'h1234 || out_rs2_val !== 32'hABCD || out_rd !== 5'd1) begin
      failures++; $display("FAIL plain_read v=%b rs1=%h rs2=%h rd=%0d exp 1 1234 abcd 1",
                           out_valid, out_rs1_val, out_rs2_val, out_rd);
    end
    drain();
  endtask

  task automatic test_wb_same_cycle();
    rf[7] = 32'h0;
    wb_we = 1; wb_wa = 5'd7; wb_wd = 32'hDEAD;
    issue(5'd7, 5'd0, 5'd2, 1, 0);
    tick();
    checks++;
    if (out_rs1_val !== 32'hDEAD || out_rs2_val !== 32'h0) begin
      failures++; $display("FAIL wb_bypass rs1=%h rs2=%h exp dead 0", out_rs1_val, out_rs2_val);
    end
    wb_wa = 5'd0; wb_wd = 32'h5555;
    issue(5'd0, 5'd0, 5'd2, 1, 0);
    tick();
    checks++;
    if (out_rs1_val !== 32'h0) begin
      failures++; $display("FAIL wb_x0 rs1=%h exp 0", out_rs1_val);
    end
    drain();
  endtask

  task automatic test_priority();
    logic [XLEN-1:0] exp_v [4];
    exp_v[0] = 32'h11; exp_v[1] = 32'h22; exp_v[2] = 32'h33; exp_v[3] = 32'h44;
    for (int k = 0; k < 4; k++) begin
      rf[3] = 32'h44;
      ex_fwd_en  = (k < 1); ex_fwd_rd  = 5'd3; ex_fwd_data  = 32'h11;
      mem_fwd_en = (k < 2); mem_fwd_rd = 5'd3; mem_fwd_data = 32'h22;
      wb_we      = (k < 3); wb_wa      = 5'd3; wb_wd        = 32'h33;
      issue(5'd1, 5'd3, 5'd4, 1, 0);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_rs2_val !== exp_v[k]) begin
        failures++; $display("FAIL priority_%0d v=%b rs2=%h exp 1 %h", k, out_valid, out_rs2_val, exp_v[k]);
      end
    end
    drain();
  endtask

  task automatic test_load_use();
    logic [31:0] s0;
    s0 = stall_cnt;
    issue(5'd0, 5'd0, 5'd9, 1, 1);
    tick();
    issue(5'd9, 5'd2, 5'd10, 1, 0);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL lu_cycle1 rdy=%b v=%b exp 0 1", in_ready, out_valid);
    end
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL lu_cycle2 rdy=%b v=%b exp 0 0", in_ready, out_valid);
    end
    tick();
    mem_fwd_en = 1; mem_fwd_rd = 5'd9; mem_fwd_data = 32'h77;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL lu_cycle3 rdy=%b v=%b exp 1 0", in_ready, out_valid);
    end
    tick();
    in_valid = 0; mem_fwd_en = 0;
    checks++;
    if (out_valid !== 1'b1 || out_rs1_val !== 32'h77 || stall_cnt - s0 !== 32'd2) begin
      failures++; $display("FAIL lu_result v=%b rs1=%h stalls=%0d exp 1 77 2", out_valid, out_rs1_val, stall_cnt - s0);
    end
    drain();
  endtask

  task automatic test_back_pressure();
    rf[5] = 32'hA5A5; rf[6] = 32'h6666;
    issue(5'd5, 5'd0, 5'd12, 1, 0);
    tick();
    out_ready = 0;
    issue(5'd6, 5'd0, 5'd13, 1, 0);
    for (int i = 0; i < 4; i++) begin
      rf[5] = $urandom;
      ex_fwd_en = 1; ex_fwd_rd = 5'd5; ex_fwd_data = $urandom;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_%0d got=%b exp=0", i, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_rs1_val !== 32'hA5A5 || out_rd !== 5'd12) begin
        failures++; $display("FAIL bp_hold_%0d v=%b rs1=%h rd=%0d exp 1 a5a5 12", i, out_valid, out_rs1_val, out_rd);
      end
    end
    ex_fwd_en = 0; out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", in_ready); end
    tick();
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || out_rd !== 5'd13 || out_rs1_val !== 32'h6666) begin
      failures++; $display("FAIL bp_next v=%b rd=%0d rs1=%h exp 1 13 6666", out_valid, out_rd, out_rs1_val);
    end
    drain();
  endtask

  task automatic test_flush();
    logic [31:0] s0;
    issue(5'd1, 5'd2, 5'd3, 1, 0);
    tick();
    s0 = stall_cnt;
    flush = 1;
    issue(5'd4, 5'd5, 5'd6, 1, 0);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
    tick();
    flush = 0; in_valid = 0;
    checks++;
    if (out_valid !== 1'b0 || stall_cnt !== s0) begin
      failures++; $display("FAIL flush_state v=%b stall=%0d exp 0 %0d", out_valid, stall_cnt, s0);
    end
    // flush while a load leaves ID/EX: no interlock survives
    issue(5'd0, 5'd0, 5'd9, 1, 1);
    tick();
    flush = 1; in_valid = 0;
    tick();
    flush = 0;
    issue(5'd9, 5'd0, 5'd11, 1, 0);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ldtrk rdy=%b exp=1", in_ready); end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    issue(5'd0, 5'd0, 5'd9, 1, 1);
    tick();
    issue(5'd9, 5'd0, 5'd14, 1, 0);
    tick();
    rst_n = 0;
    tick();
    #1;
    checks++;
    if (stall_cnt !== 32'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL mid_reset stall=%0d v=%b rdy=%b exp 0 0 0", stall_cnt, out_valid, in_ready);
    end
    checks++;
    if (out_rs1_val !== '0 || out_rs2_val !== '0 || out_rd !== '0 || out_rd_wr !== 0 || out_is_load !== 0) begin
      failures++; $display("FAIL mid_reset_fields rs1=%h rd=%0d ld=%b exp 0", out_rs1_val, out_rd, out_is_load);
    end
    rst_n = 1;
    drain();
  endtask

  // Randomized run: the model holds the ID/EX entry as a transaction and a
  // list of load destinations that entered EX in the previous cycle.
  task automatic test_random();
    bit              m_valid = 0;
    logic [XLEN-1:0] m_v1 = 0, m_v2 = 0;
    logic [AW-1:0]   m_rd = 0;
    bit              m_wr = 0, m_ld = 0;
    logic [AW-1:0]   loads_in_ex [$];
    logic [31:0]     m_stall;
    logic [XLEN-1:0] e1, e2;
    logic [AW-1:0]   r;
    bit              hz, rdy, dep_id, dep_ex;
    m_stall = stall_cnt;
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      in_rs1     = AW'($urandom_range(0, 7));
      in_rs2     = AW'($urandom_range(0, 7));
      in_rd      = AW'($urandom_range(0, 7));
      in_rd_wr   = ($urandom_range(0, 3) != 0);
      in_is_load = ($urandom_range(0, 9) < 3);
      out_ready  = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 19) == 0);
      ex_fwd_en  = $urandom_range(0, 1); ex_fwd_rd  = AW'($urandom_range(0, 7)); ex_fwd_data  = $urandom;
      mem_fwd_en = $urandom_range(0, 1); mem_fwd_rd = AW'($urandom_range(0, 7)); mem_fwd_data = $urandom;
      wb_we      = $urandom_range(0, 1); wb_wa      = AW'($urandom_range(0, 7)); wb_wd        = $urandom;

      dep_id = m_valid && m_ld && m_wr && in_rd_wr_dep(m_rd);
      dep_ex = 0;
      foreach (loads_in_ex[j]) if (in_rd_wr_dep(loads_in_ex[j])) dep_ex = 1;
      hz  = in_valid && (dep_id || dep_ex);
      rdy = (!m_valid || out_ready) && !hz && !flush;

      e1 = 0; e2 = 0;
      for (int s = 0; s < 2; s++) begin
        logic [XLEN-1:0] v;
        r = (s == 0) ? in_rs1 : in_rs2;
        if (r == 0) v = 0;
        else if (ex_fwd_en && ex_fwd_rd == r) v = ex_fwd_data;
        else if (mem_fwd_en && mem_fwd_rd == r) v = mem_fwd_data;
        else if (wb_we && wb_wa == r) v = wb_wd;
        else v = rf[r];
        if (s == 0) e1 = v; else e2 = v;
      end

      #1;
      checks++;
      if (in_ready !== rdy) begin
        failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, in_ready, rdy);
      end

      if (m_valid && out_ready && m_ld && m_wr && m_rd != 0 && !flush) begin
        loads_in_ex = '{m_rd};
      end else begin
        loads_in_ex = '{};
      end
      if (hz && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (flush) m_valid = 0;
      else if (in_valid && rdy) begin
        m_valid = 1; m_v1 = e1; m_v2 = e2; m_rd = in_rd; m_wr = in_rd_wr; m_ld = in_is_load;
      end else if (out_ready) m_valid = 0;

      tick();
      checks++;
      if (out_valid !== m_valid || stall_cnt !== m_stall) begin
        failures++; $display("FAIL rnd_state cyc=%0d v=%b stall=%0d exp %b %0d", cyc, out_valid, stall_cnt, m_valid, m_stall);
      end
      if (m_valid) begin
        checks++;
        if (out_rs1_val !== m_v1 || out_rs2_val !== m_v2 || out_rd !== m_rd ||
            out_rd_wr !== m_wr || out_is_load !== m_ld) begin
          failures++; $display("FAIL rnd_entry cyc=%0d rs1=%h rs2=%h rd=%0d wr=%b ld=%b exp %h %h %0d %b %b",
                               cyc, out_rs1_val, out_rs2_val, out_rd, out_rd_wr, out_is_load,
                               m_v1, m_v2, m_rd, m_wr, m_ld);
        end
      end
    end
    drain();
  endtask

  function automatic bit in_rd_wr_dep(input logic [AW-1:0] d);
    return (d != 0) && (in_rs1 == d || in_rs2 == d);
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_plain_read();
    test_wb_same_cycle();
    test_priority();
    test_load_use();
    test_back_pressure();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode-side read end of the integer register file: drives the file's two asynchronous read addresses, collects the operands and registers them into the ID/EX pipeline register.
- Resolves read-after-write hazards by bypassing from EX, MEM and WB (WB covers the same-cycle write the file does not yet return).
- Detects load-use hazards, inserts bubbles and counts stall cycles.

Parameters:
- XLEN, 32, operand and data width
- AW, 5, register address width (32 registers, x0 hard-wired zero)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  synchronous active-low reset
- flush  in  1  synchronous kill of the ID/EX register contents
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted this cycle when in_valid&in_ready
- in_rs1, in_rs2, in_rd  in  AW  source and destination register numbers
- in_rd_wr  in  1  instruction writes rd
- in_is_load  in  1  instruction is a load
- rf_ra1, rf_ra2  out  AW  register-file read addresses
- rf_rd1, rf_rd2  in  XLEN  register-file read data (async)
- ex_fwd_en, ex_fwd_rd, ex_fwd_data  in  1/AW/XLEN  EX result bypass; never asserted for loads
- mem_fwd_en, mem_fwd_rd, mem_fwd_data  in  1/AW/XLEN  MEM-stage bypass, including load data
- wb_we, wb_wa, wb_wd  in  1/AW/XLEN  writeback port, same signals the register file writes with
- out_valid  out  1  ID/EX register holds an instruction
- out_ready  in  1  EX consumes when out_valid&out_ready
- out_rs1_val, out_rs2_val  out  XLEN  resolved operands
- out_rd  out  AW  registered destination number
- out_rd_wr, out_is_load  out  1  registered control bits
- stall_cnt  out  32  load-use stall cycles counted since reset

Behaviour:
Read addressing
- rf_ra1=in_rs1 and rf_ra2=in_rs2, combinational and independent of in_valid.

Operand select, per source rsN, combinational:
- rsN==0 gives 0.
- Otherwise the first matching source in this priority wins: ex_fwd_en&ex_fwd_rd==rsN, then mem_fwd_en&mem_fwd_rd==rsN, then wb_we&wb_wa==rsN, then rf_rdN.
- Any bypass whose rd/wa is 0 is ignored.

Load tracking
- ld_trk_valid/ld_trk_rd is set for one cycle when the ID/EX register is consumed (out_valid&out_ready) holding a load with out_rd_wr and out_rd!=0.
- Otherwise it clears.
- It represents a load currently in EX whose data is not yet bypassable.

Hazard
- hz=in_valid & (rs1 or rs2 nonzero and equal to the load destination) for either of:
  - out_valid&out_is_load&out_rd_wr
  - ld_trk_valid
- A dependent instruction directly behind a load sees exactly 2 bubbles.

Handshake
- in_ready = (~out_valid | out_ready) & ~hz & ~flush.
- On accept, the ID/EX register loads operands and control and out_valid=1.
- If out_ready and nothing accepted, out_valid=0 (bubble).
- If ~out_ready&out_valid, the register holds all fields stable.
- Latency: accept in cycle N gives out_valid in cycle N+1.
- Operands are sampled at accept; later bypasses do not update a held entry. Upstream ordering guarantees a held entry has no pending producer.

stall_cnt
- Increments by 1 each cycle hz=1 (saturating at 2^32-1).
- Flush does not clear it.

Flush
- Next cycle out_valid=0 and ld_trk_valid=0; in_ready=0 during the flush cycle.
- Flush beats a simultaneous accept.

Reset (rst_n=0 at posedge)
- out_valid=0, ld_trk_valid=0, stall_cnt=0.
- out_rs1_val/out_rs2_val=0, out_rd=0, out_rd_wr=0, out_is_load=0.
- in_ready reads 0 while rst_n=0.
- Mid-operation reset discards the held entry with no partial update.

Test Plan:
- Plain read: RF x5=0x1234, x6=0xABCD, no bypass; issue rs1=5, rs2=6, out_ready=1 -> next cycle out_valid=1, out_rs1_val=0x1234, out_rs2_val=0xABCD.
- Same-cycle WB: wb_we=1, wb_wa=7, wb_wd=0xDEAD while issuing rs1=7 (RF still old 0x0) -> out_rs1_val=0xDEAD; same with wb_wa=0 and rs1=0 -> out_rs1_val=0.
- Priority: ex_fwd(rd=3, data=0x11), mem_fwd(rd=3, data=0x22), wb(wa=3, data=0x33), issue rs2=3 -> out_rs2_val=0x11; drop ex_fwd -> 0x22; drop mem_fwd -> 0x33.
- Load-use: accept load rd=9, then dependent rs1=9 with out_ready=1 -> in_ready=0 for exactly 2 cycles, 2 bubbles on out_valid, stall_cnt=2. Third cycle with mem_fwd(rd=9, data=0x77) -> accepted, out_rs1_val=0x77.
- Backpressure: out_valid=1, out_ready=0 for 4 cycles with new in_valid -> in_ready=0, outputs unchanged. Raise out_ready -> new entry next cycle.
- Flush/reset: flush together with in_valid&out_ready -> no accept, out_valid=0 next cycle, stall_cnt kept. rst_n=0 mid-stall -> stall_cnt=0, out_valid=0, all out fields 0.
